// File: rtl/nios_systemv2_mem_test_master_pkg.sv
// nios_systemv2_mem_test_master_pkg: shared FSM states, error-counter width and test pattern.
package nios_systemv2_mem_test_master_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    function automatic logic [63:0] pattern(input logic [63:0] seed, input logic [63:0] idx);
        return seed ^ idx;
    endfunction

endpackage

// File: rtl/nios_systemv2_mem_test_master_if.sv
// nios_systemv2_mem_test_master_if: Avalon-MM master/slave bus bundle.
interface nios_systemv2_mem_test_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (output address, read, write, writedata, byteenable, input readdata, waitrequest);
    modport slave  (input address, read, write, writedata, byteenable, output readdata, waitrequest);
endinterface

// File: rtl/nios_systemv2_mem_test_master_rd_pipe.sv
// nios_systemv2_mem_test_master_rd_pipe: DEPTH-deep valid/index shift register tracking outstanding reads.
module nios_systemv2_mem_test_master_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             empty_o
);
    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0][IDX_W-1:0] ix_q;

    // Concatenate-and-truncate shifts toward the tail and also covers DEPTH==1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_q  <= '0;
            ix_q <= '0;
        end else begin
            v_q  <= DEPTH'({v_q, push_i});
            ix_q <= (DEPTH*IDX_W)'({ix_q, idx_i});
        end
    end

    assign valid_o = v_q[DEPTH-1];
    assign idx_o   = ix_q[DEPTH-1];
    assign empty_o = ~|v_q;
endmodule

// File: rtl/nios_systemv2_mem_test_master.sv
// nios_systemv2_mem_test_master: Avalon-MM memory BIST master; writes seed^i over a word range,
// reads it back and reports mismatch count and first failing address.
module nios_systemv2_mem_test_master
    import nios_systemv2_mem_test_master_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic [CNT_W-1:0]   word_count_i,
    input  logic [DATA_W-1:0]  seed_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ERR_W-1:0]   err_count_o,
    output logic [ADDR_W-1:0]  first_err_addr_o,
    nios_systemv2_mem_test_master_if.master avm
);
    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   base_q;
    logic [CNT_W-1:0]    cnt_q, idx_q, idx_d, pipe_idx;
    logic [DATA_W-1:0]   seed_q, rexp;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;
    logic                pass_q, done_q;
    logic                rd, wr, wr_acc, rd_acc, start_acc, last, pipe_v, pipe_empty, mism;
    logic                unused_ok;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] i);
        return {base_q + (ADDR_W-2)'(i), 2'b00};
    endfunction

    assign unused_ok = &{1'b0, base_addr_i[1:0]};

    assign rd        = state_q == S_READ;
    assign wr        = state_q == S_WRITE;
    assign wr_acc    = wr & ~avm.waitrequest;
    assign rd_acc    = rd & ~avm.waitrequest;
    assign start_acc = (state_q == S_IDLE) & start_i;
    assign last      = idx_q == cnt_q - CNT_W'(1);

    assign avm.read       = rd;
    assign avm.write      = wr;
    assign avm.address    = addr_of(idx_q);
    assign avm.writedata  = DATA_W'(pattern(64'(seed_q), 64'(idx_q)));
    assign avm.byteenable = {(DATA_W/8){rd | wr}};

    nios_systemv2_mem_test_master_rd_pipe #(.DEPTH(READ_LATENCY), .IDX_W(CNT_W)) u_rd_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (rd_acc),
        .idx_i   (idx_q),
        .valid_o (pipe_v),
        .idx_o   (pipe_idx),
        .empty_o (pipe_empty)
    );

    assign rexp   = DATA_W'(pattern(64'(seed_q), 64'(pipe_idx)));
    assign mism   = pipe_v & (avm.readdata != rexp);
    assign err_d  = (mism && err_q != '1) ? err_q + ERR_W'(1) : err_q;
    assign ferr_d = (mism && err_q == '0) ? addr_of(pipe_idx) : ferr_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = (word_count_i == '0) ? S_DONE : S_WRITE;
                if (start_i) idx_d = '0;
            end
            S_WRITE: begin
                if (wr_acc) idx_d = last ? '0 : idx_q + CNT_W'(1);
                if (wr_acc && last) state_d = S_READ;
            end
            S_READ: begin
                if (rd_acc) idx_d = idx_q + CNT_W'(1);
                if (rd_acc && last) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = pipe_empty ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= state_q == S_DONE;
            if (start_acc) begin
                base_q <= base_addr_i[ADDR_W-1:2];
                cnt_q  <= word_count_i;
                seed_q <= seed_i;
                err_q  <= '0;
                ferr_q <= '0;
                pass_q <= 1'b0;
            end else begin
                err_q  <= err_d;
                ferr_q <= ferr_d;
                if (state_q == S_DONE) pass_q <= err_q == '0;
            end
        end
    end

    assign busy_o           = state_q != S_IDLE;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_q;
endmodule

// File: tb/tb_nios_systemv2_mem_test_master.sv
// tb_nios_systemv2_mem_test_master: directed + random BIST runs against a 1024x32 RAM model with optional stalls.
module tb_nios_systemv2_mem_test_master;
    logic        clk = 1'b0;
    logic        reset_n, start, busy, done, pass;
    logic [11:0] base_addr, first_err_addr;
    logic [10:0] word_count;
    logic [31:0] seed;
    logic [15:0] err_count;
    bit          stall_en, corrupt_en, stall_w;
    int          total = 0, bad = 0;
    int          done_cnt = 0, overlap = 0, be_bad = 0, unstable = 0;
    logic [11:0] wr_a[$], rd_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] mem [1024];

    nios_systemv2_mem_test_master_if #(.ADDR_W(12), .DATA_W(32)) avm ();

    nios_systemv2_mem_test_master dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start_i          (start),
        .base_addr_i      (base_addr),
        .word_count_i     (word_count),
        .seed_i           (seed),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_count_o      (err_count),
        .first_err_addr_o (first_err_addr),
        .avm              (avm)
    );

    always #5 clk = ~clk;

    assign avm.waitrequest = stall_w;

    // Slave RAM with one-cycle registered read; optionally flips bit 0 of the word stored at 0x010.
    always @(posedge clk) begin
        if (avm.write && !avm.waitrequest)
            mem[avm.address[11:2]] <= (corrupt_en && avm.address == 12'h010) ? avm.writedata ^ 32'd1 : avm.writedata;
        if (avm.read && !avm.waitrequest) avm.readdata <= mem[avm.address[11:2]];
    end

    bit          prev_stall = 1'b0;
    logic        prev_rd, prev_wr;
    logic [11:0] prev_a;
    logic [31:0] prev_wd;

    always @(negedge clk) begin
        bit w;
        if (avm.read && avm.write) overlap++;
        if ((avm.read || avm.write) && avm.byteenable !== 4'hF) be_bad++;
        if (reset_n && prev_stall && (avm.read !== prev_rd || avm.write !== prev_wr ||
            avm.address !== prev_a || (prev_wr && avm.writedata !== prev_wd))) unstable++;
        if (done) done_cnt++;
        w = stall_en && ($urandom_range(0, 99) < 30);
        stall_w = w;
        if (reset_n && avm.write && !w) begin
            wr_a.push_back(avm.address);
            wr_d.push_back(avm.writedata);
        end
        if (reset_n && avm.read && !w) rd_a.push_back(avm.address);
        prev_stall = (avm.read || avm.write) && w;
        prev_rd = avm.read;
        prev_wr = avm.write;
        prev_a  = avm.address;
        prev_wd = avm.writedata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [11:0] b, input logic [10:0] n, input logic [31:0] sd, input bit st, input bit cor);
        int          cyc, exp_err, d0;
        logic [11:0] exp_first, a;
        logic [31:0] p, rb;
        wr_a.delete();
        wr_d.delete();
        rd_a.delete();
        overlap = 0;
        be_bad = 0;
        unstable = 0;
        stall_en = st;
        corrupt_en = cor;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        word_count = n;
        seed = sd;
        @(negedge clk);
        start = 1'b0;
        base_addr = 12'($urandom);
        word_count = 11'($urandom);
        seed = $urandom;
        cyc = 1;
        chk("busy_after_start", 64'(busy), 64'd1);
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 5 && n > 4);
        end
        start = 1'b0;
        chk("done_within_bound", 64'(cyc < 5000), 64'd1);
        if (!st) chk("start_to_done_cycles", 64'(cyc), (n == 0) ? 64'd2 : 64'(2 * int'(n) + 4));
        chk("busy_low_at_done", 64'(busy), 64'd0);
        exp_err = 0;
        exp_first = 12'h000;
        for (int i = 0; i < int'(n); i++) begin
            a  = 12'((int'(b) & 'hFFC) + 4 * i);
            p  = sd ^ 32'(i);
            rb = (cor && a == 12'h010) ? p ^ 32'd1 : p;
            if (rb != p) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
            if (i < wr_a.size()) begin
                chk("wr_addr", 64'(wr_a[i]), 64'(a));
                chk("wr_data", 64'(wr_d[i]), 64'(p));
            end
            if (i < rd_a.size()) chk("rd_addr", 64'(rd_a[i]), 64'(a));
        end
        chk("wr_count", 64'(wr_a.size()), 64'(n));
        chk("rd_count", 64'(rd_a.size()), 64'(n));
        chk("err_count", 64'(err_count), 64'(exp_err));
        chk("first_err_addr", 64'(first_err_addr), 64'(exp_first));
        chk("pass", 64'(pass), 64'(exp_err == 0));
        chk("rd_wr_overlap", 64'(overlap), 64'd0);
        chk("byteenable", 64'(be_bad), 64'd0);
        chk("stall_stability", 64'(unstable), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("pass_held", 64'(pass), 64'(exp_err == 0));
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0, cyc;
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        seed = '0;
        stall_en = 1'b0;
        corrupt_en = 1'b0;
        stall_w = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_first", 64'(first_err_addr), 64'd0);
        chk("rst_read", 64'(avm.read), 64'd0);
        chk("rst_write", 64'(avm.write), 64'd0);
        chk("rst_addr", 64'(avm.address), 64'd0);
        chk("rst_wdata", 64'(avm.writedata), 64'd0);
        chk("rst_be", 64'(avm.byteenable), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run(12'h000, 11'd16, 32'hA5A5_0000, 1'b0, 1'b0);
        run(12'h123, 11'd0, $urandom, 1'b0, 1'b0);
        run(12'hFF8, 11'd4, $urandom, 1'b0, 1'b0);
        chk("wrap_addr2", 64'(rd_a.size() > 2 ? rd_a[2] : 12'hFFF), 64'h000);
        run(12'h000, 11'd8, $urandom, 1'b0, 1'b1);
        chk("corrupt_err", 64'(err_count), 64'd1);
        chk("corrupt_first", 64'(first_err_addr), 64'h010);
        run(12'h400, 11'd64, $urandom, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            run(12'($urandom), 11'($urandom_range(1, 40)), $urandom, 1'b1, 1'($urandom_range(0, 1)));

        stall_en = 1'b0;
        corrupt_en = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        base_addr = 12'h100;
        word_count = 11'd64;
        seed = $urandom;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!avm.read && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_read", 64'(avm.read), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_read", 64'(avm.read), 64'd0);
        chk("abort_write", 64'(avm.write), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_pass", 64'(pass), 64'd0);
        run(12'h200, 11'd20, $urandom, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
